// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int DW    = 16;
    localparam int VW    = 8;
    localparam int ITER  = DW;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dvs_i,
    output logic [VW-1:0] rem_o,
    output logic          q_o
);

    logic [VW:0]   sh;
    logic [VW+1:0] diff;

    always_comb begin
        sh   = {rem_i, bit_i};
        diff = {1'b0, sh} - {2'b00, dvs_i};
        q_o  = ~diff[VW+1];
        // A kept difference is below |divisor| and a restored value was too,
        // so both fit back into VW bits.
        rem_o = q_o ? VW'(diff) : VW'(sh);
    end

endmodule

// File: rtl/seq_div.sv
// Sequential signed restoring divider: one quotient bit per clock, start/done handshake.
module seq_div #(
    parameter int DW = div_pkg::DW,
    parameter int VW = div_pkg::VW
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic signed [DW-1:0] DIVIDEND,
    input  logic signed [VW-1:0] DIVISOR,
    output logic                 BUSY,
    output logic                 DONE,
    output logic signed [DW-1:0] Q,
    output logic signed [VW-1:0] R,
    output logic                 DIV0,
    output logic                 OVF
);

    import div_pkg::*;

    localparam int CW = $clog2(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          div0_q, div0_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [DW-1:0] abs_dvd;
    logic [VW-1:0] abs_dvs;
    logic [VW-1:0] step_rem;
    logic          step_q;

    // Two's-complement negation of the most negative value yields its
    // magnitude read as unsigned, so DW/VW bits are enough here.
    assign abs_dvd = DIVIDEND[DW-1] ? (~DIVIDEND + DW'(1)) : DIVIDEND;
    assign abs_dvs = DIVISOR[VW-1]  ? (~DIVISOR  + VW'(1)) : DIVISOR;

    div_step #(.VW(VW)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DW-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    sa_d    = DIVIDEND[DW-1];
                    sb_d    = DIVISOR[VW-1];
                    dvd_d   = abs_dvd;
                    dvs_d   = abs_dvs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_d     = '0;
                    r_d     = '0;
                    div0_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (DIVISOR == '0) ? SIGN : CALC;
                end
            end
            CALC: begin
                // Quotient bits shift into the dividend register as its bits are consumed.
                rem_d = step_rem;
                dvd_d = {dvd_q[DW-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dvs_q == '0) begin
                    div0_d = 1'b1;
                end else begin
                    q_d   = (sa_q ^ sb_q) ? (~dvd_q + DW'(1)) : dvd_q;
                    r_d   = sa_q ? (~rem_q + VW'(1)) : rem_q;
                    // A positive quotient with the MSB set can only be -2^(DW-1) / -1.
                    ovf_d = ~(sa_q ^ sb_q) & dvd_q[DW-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign DIV0 = div0_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed scenarios plus random operands against integer / and %.
module tb_seq_div;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               START = 1'b0;
    logic signed [15:0] DIVIDEND = '0;
    logic signed [7:0]  DIVISOR = '0;
    logic               BUSY, DONE, DIV0, OVF;
    logic signed [15:0] Q;
    logic signed [7:0]  R;

    int n_chk = 0;
    int n_pass = 0;

    seq_div #(.DW(16), .VW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIV0(DIV0), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // Issue one operation from a point 1 time unit after a rising edge; lat ends as
    // the number of edges after the accepting edge until DONE is seen (capped at 40).
    task automatic do_op(input int a, input int b, output int lat, output int busy_cyc);
        DIVIDEND = 16'(a);
        DIVISOR  = 8'(b);
        START    = 1'b1;
        @(posedge CLK); #1;
        START    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_cyc++;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_chk++; if ({BUSY, DONE, DIV0, OVF} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {BUSY, DONE, DIV0, OVF}); else n_pass++;
        n_chk++; if (Q !== 16'sd0) $display("FAIL reset_q got %0d want 0", Q); else n_pass++;
        n_chk++; if (R !== 8'sd0) $display("FAIL reset_r got %0d want 0", R); else n_pass++;
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        int lat, bc;
        do_op(1000, 7, lat, bc);
        n_chk++; if (lat != 17) $display("FAIL basic_latency got %0d want 17", lat); else n_pass++;
        n_chk++; if (bc != 17) $display("FAIL basic_busy_cycles got %0d want 17", bc); else n_pass++;
        n_chk++; if (BUSY !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", BUSY); else n_pass++;
        n_chk++; if (Q !== 16'sd142 || R !== 8'sd6) $display("FAIL basic_qr got %0d/%0d want 142/6", Q, R); else n_pass++;
        n_chk++; if ({DIV0, OVF} !== 2'b00) $display("FAIL basic_flags got %b want 00", {DIV0, OVF}); else n_pass++;
        repeat (4) @(posedge CLK);
        #1;
        n_chk++; if (DONE !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", DONE); else n_pass++;
        n_chk++; if (Q !== 16'sd142 || R !== 8'sd6) $display("FAIL basic_hold got %0d/%0d want 142/6", Q, R); else n_pass++;
    endtask

    task automatic test_signs();
        int av[4] = '{-1000, 1000, -128, -32767};
        int bv[4] = '{7, -7, -128, -128};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], lat, bc);
            n_chk++;
            if (lat != 17 || Q !== 16'(av[i] / bv[i]) || R !== 8'(av[i] % bv[i]))
                $display("FAIL sign_%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=17",
                         i, Q, R, lat, av[i] / bv[i], av[i] % bv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div0_ovf();
        int lat, bc;
        do_op(100, 0, lat, bc);
        n_chk++; if (lat != 1) $display("FAIL div0_latency got %0d want 1", lat); else n_pass++;
        n_chk++; if ({DIV0, OVF} !== 2'b10 || Q !== 16'sd0 || R !== 8'sd0)
            $display("FAIL div0_result got div0=%b ovf=%b q=%0d r=%0d want 1 0 0 0", DIV0, OVF, Q, R); else n_pass++;
        do_op(-32768, -1, lat, bc);
        n_chk++; if (lat != 17) $display("FAIL ovf_latency got %0d want 17", lat); else n_pass++;
        n_chk++; if ({DIV0, OVF} !== 2'b01 || Q !== 16'sh8000 || R !== 8'sd0)
            $display("FAIL ovf_result got div0=%b ovf=%b q=%h r=%0d want 0 1 8000 0", DIV0, OVF, Q, R); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        DIVIDEND = 16'sd1000;
        DIVISOR  = 8'sd7;
        START    = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat   = 0;
        while (!DONE && lat < 40) begin
            // A second request mid-operation must be dropped.
            if (lat == 5) begin
                START = 1'b1; DIVIDEND = 16'sd50; DIVISOR = 8'sd3;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        n_chk++; if (lat != 17 || Q !== 16'sd142 || R !== 8'sd6)
            $display("FAIL busy_ignore got q=%0d r=%0d lat=%0d want 142 6 17", Q, R, lat); else n_pass++;
        @(posedge CLK); #1;
        n_chk++; if (BUSY !== 1'b0) $display("FAIL busy_ignore_idle got %b want 0", BUSY); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        bit both;
        do_op(1000, 7, lat, bc);
        n_chk++; if (!DONE) $display("FAIL b2b_first_done got %b want 1", DONE); else n_pass++;
        DIVIDEND = 16'sd50;
        DIVISOR  = 8'sd3;
        START    = 1'b1;
        gap  = 0;
        both = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        gap   = 1;
        while (!DONE && gap < 40) begin
            if (BUSY && DONE) both = 1'b1;
            @(posedge CLK); #1;
            gap++;
        end
        if (BUSY && DONE) both = 1'b1;
        n_chk++; if (gap != 18) $display("FAIL b2b_gap got %0d want 18", gap); else n_pass++;
        n_chk++; if (Q !== 16'sd16 || R !== 8'sd2) $display("FAIL b2b_qr got %0d/%0d want 16/2", Q, R); else n_pass++;
        n_chk++; if (both) $display("FAIL b2b_busy_done_overlap got 1 want 0"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit saw_done;
        DIVIDEND = 16'sd1000;
        DIVISOR  = 8'sd7;
        START    = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        n_chk++; if ({BUSY, DONE} !== 2'b00 || Q !== 16'sd0 || R !== 8'sd0)
            $display("FAIL reset_mid got busy=%b done=%b q=%0d r=%0d want 0 0 0 0", BUSY, DONE, Q, R); else n_pass++;
        RST_N    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) saw_done = 1'b1;
        end
        n_chk++; if (saw_done) $display("FAIL reset_mid_aborted got activity want none"); else n_pass++;
        do_op(-1000, -7, lat, bc);
        n_chk++; if (lat != 17 || Q !== 16'sd142 || R !== -8'sd6)
            $display("FAIL reset_mid_restart got q=%0d r=%0d lat=%0d want 142 -6 17", Q, R, lat); else n_pass++;
    endtask

    task automatic test_random(input int n);
        int a, b, qe, re, lat, bc, bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 254)) - 128;
            if (b >= 0) b++;
            if (i % 16 == 0) a = -32768;
            if (i % 16 == 1) a = 32767;
            if (a == -32768 && b == -1) b = 1;
            qe = a / b;
            re = a % b;
            do_op(a, b, lat, bc);
            n_chk++;
            if (lat != 17 || Q !== 16'(qe) || R !== 8'(re) || OVF || DIV0) begin
                $display("FAIL rand_%0d %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=17",
                         i, a, b, Q, R, lat, qe, re);
                bad++;
            end else n_pass++;
            n_chk++;
            if (int'(Q) * b + int'(R) != a || (R != 0 && ((R < 0) != (a < 0))))
                $display("FAIL rand_identity_%0d %0d/%0d got q=%0d r=%0d", i, a, b, Q, R);
            else n_pass++;
            if (bad > 10) break;
        end
    endtask

    initial begin
        @(posedge CLK); #1;
        test_reset();
        test_basic();
        test_signs();
        test_div0_ovf();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random(2000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
